// File: rtl/fan_in_resp_bridge_pkg.sv
// Shared definitions for the two-input response merger.
//   - Default widths of the response payload fields.
//   - PTR_W: pointer width for the default FIFO depth.
//   - resp_width(): packed width of one {rdata, rtag, opc, aux} entry.
package fan_in_resp_bridge_pkg;

  localparam int unsigned RESP_DATA_WIDTH = 32;
  localparam int unsigned RESP_AUX_WIDTH  = 6;
  localparam int unsigned RESP_TAG_WIDTH  = RESP_DATA_WIDTH / 8;
  localparam int unsigned FIFO_DEPTH      = 4;
  localparam int unsigned PTR_W           = $clog2(FIFO_DEPTH);

  // Entry layout, MSB first: {rdata, rtag, opc, aux}.
  function automatic int unsigned resp_width(input int unsigned data_w,
                                             input int unsigned tag_w,
                                             input int unsigned aux_w);
    return data_w + tag_w + 1 + aux_w;
  endfunction

endpackage

// File: rtl/resp_fifo_flowthrough.sv
// Flow-through response FIFO.
//   clk, rst   : clock and asynchronous active-high reset
//   push       : write push_data this cycle
//   push_data  : incoming entry
//   pop        : consume the head entry (or the bypassed push when empty)
//   data_o     : head entry; the incoming push_data while the FIFO is empty
//   empty/full : occupancy flags from the registered count
//   count      : registered occupancy, 0..DEPTH
// A push to a full FIFO without a same-cycle pop is dropped.
module resp_fifo_flowthrough #(
  parameter int unsigned WIDTH = 44,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             wr_en, rd_en;

  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_CNT);
  assign count  = count_q;
  assign data_o = empty ? push_data : mem_q[rd_ptr_q];

  // An empty FIFO that is popped in the push cycle passes the entry straight through.
  assign wr_en = push & ~(empty & pop) & (~full | pop);
  assign rd_en = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fan_in_resp_arbiter_bridge.sv
// Two-input response merger: two flow-through FIFOs drained one entry per
// cycle into a registered downstream response port.
//   clk, rst              : clock, asynchronous active-high reset
//   data_r_*0_i / *1_i    : response sources 0 and 1 (no backpressure)
//   data_r_*_o            : merged response, valid is a one-cycle pulse
//   data_r_src_o          : source index of the current output
//   stall0_o / stall1_o   : FIFO occupancy >= STALL_TH
//   overflow_o            : sticky, a push was dropped on a full FIFO
// Build option FAN_IN_RESP_FIXED_PRIO_EN: source 0 always wins (no round-robin).
module fan_in_resp_arbiter_bridge
  import fan_in_resp_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned AUX_WIDTH  = 6,
  parameter int unsigned BYTE_NUM   = DATA_WIDTH / 8,
  parameter int unsigned TAG_WIDTH  = BYTE_NUM,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STALL_TH   = FIFO_DEPTH - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_r_rdata0_i,
  input  logic [TAG_WIDTH-1:0]  data_r_rtag0_i,
  input  logic                  data_r_opc0_i,
  input  logic [AUX_WIDTH-1:0]  data_r_aux0_i,
  input  logic                  data_r_valid0_i,
  input  logic [DATA_WIDTH-1:0] data_r_rdata1_i,
  input  logic [TAG_WIDTH-1:0]  data_r_rtag1_i,
  input  logic                  data_r_opc1_i,
  input  logic [AUX_WIDTH-1:0]  data_r_aux1_i,
  input  logic                  data_r_valid1_i,
  output logic [DATA_WIDTH-1:0] data_r_rdata_o,
  output logic [TAG_WIDTH-1:0]  data_r_rtag_o,
  output logic                  data_r_opc_o,
  output logic [AUX_WIDTH-1:0]  data_r_aux_o,
  output logic                  data_r_valid_o,
  output logic                  data_r_src_o,
  output logic                  stall0_o,
  output logic                  stall1_o,
  output logic                  overflow_o
);

  localparam int unsigned RESP_W     = resp_width(DATA_WIDTH, TAG_WIDTH, AUX_WIDTH);
  localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [FIFO_PTR_W:0] STALL_CNT = (FIFO_PTR_W + 1)'(STALL_TH);

  logic [RESP_W-1:0]   in0, in1, head0, head1, win_data;
  logic                empty0, empty1, full0, full1;
  logic [FIFO_PTR_W:0] count0, count1;
  logic                avail0, avail1, win_valid, win_sel, pop0, pop1, ovf_hit;

  assign in0 = {data_r_rdata0_i, data_r_rtag0_i, data_r_opc0_i, data_r_aux0_i};
  assign in1 = {data_r_rdata1_i, data_r_rtag1_i, data_r_opc1_i, data_r_aux1_i};

  resp_fifo_flowthrough #(.WIDTH(RESP_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk      (clk),
    .rst      (rst),
    .push     (data_r_valid0_i),
    .push_data(in0),
    .pop      (pop0),
    .data_o   (head0),
    .empty    (empty0),
    .full     (full0),
    .count    (count0)
  );

  resp_fifo_flowthrough #(.WIDTH(RESP_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk      (clk),
    .rst      (rst),
    .push     (data_r_valid1_i),
    .push_data(in1),
    .pop      (pop1),
    .data_o   (head1),
    .empty    (empty1),
    .full     (full1),
    .count    (count1)
  );

  // A FIFO is a candidate if it holds data or an entry is flowing through it.
  assign avail0    = ~empty0 | data_r_valid0_i;
  assign avail1    = ~empty1 | data_r_valid1_i;
  assign win_valid = avail0 | avail1;

`ifdef FAN_IN_RESP_FIXED_PRIO_EN
  assign win_sel = ~avail0;
`else
  logic rr_q;

  assign win_sel = (avail0 & avail1) ? rr_q : avail1;

  // The pointer only moves on contention, and then to the losing port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else if (avail0 & avail1) begin
      rr_q <= ~win_sel;
    end
  end
`endif

  assign pop0     = avail0 & ~win_sel;
  assign pop1     = avail1 & win_sel;
  assign win_data = win_sel ? head1 : head0;
  assign ovf_hit  = (data_r_valid0_i & full0 & ~pop0) | (data_r_valid1_i & full1 & ~pop1);

  assign stall0_o = (count0 >= STALL_CNT);
  assign stall1_o = (count1 >= STALL_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r_rdata_o <= '0;
      data_r_rtag_o  <= '0;
      data_r_opc_o   <= 1'b0;
      data_r_aux_o   <= '0;
      data_r_valid_o <= 1'b0;
      data_r_src_o   <= 1'b0;
      overflow_o     <= 1'b0;
    end else begin
      data_r_valid_o <= win_valid;
      if (win_valid) begin
        {data_r_rdata_o, data_r_rtag_o, data_r_opc_o, data_r_aux_o} <= win_data;
        data_r_src_o <= win_sel;
      end
      if (ovf_hit) overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fan_in_resp_arbiter_bridge.sv
// Directed self-checking bench for fan_in_resp_arbiter_bridge.
// Honours FAN_IN_RESP_FIXED_PRIO_EN for the arbitration-order expectations.
module tb_fan_in_resp_arbiter_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rdata0 = '0, rdata1 = '0;
  logic [3:0]  rtag0 = 4'h3, rtag1 = 4'hC;
  logic        opc0 = 1'b0, opc1 = 1'b1;
  logic [5:0]  aux0 = 6'h05, aux1 = 6'h2A;
  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic [31:0] rdata_o;
  logic [3:0]  rtag_o;
  logic        opc_o;
  logic [5:0]  aux_o;
  logic        valid_o, src_o, stall0, stall1, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fan_in_resp_arbiter_bridge dut (
    .clk            (clk),
    .rst            (rst),
    .data_r_rdata0_i(rdata0),
    .data_r_rtag0_i (rtag0),
    .data_r_opc0_i  (opc0),
    .data_r_aux0_i  (aux0),
    .data_r_valid0_i(valid0),
    .data_r_rdata1_i(rdata1),
    .data_r_rtag1_i (rtag1),
    .data_r_opc1_i  (opc1),
    .data_r_aux1_i  (aux1),
    .data_r_valid1_i(valid1),
    .data_r_rdata_o (rdata_o),
    .data_r_rtag_o  (rtag_o),
    .data_r_opc_o   (opc_o),
    .data_r_aux_o   (aux_o),
    .data_r_valid_o (valid_o),
    .data_r_src_o   (src_o),
    .stall0_o       (stall0),
    .stall1_o       (stall1),
    .overflow_o     (overflow)
  );

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [31:0] d0,
                       input logic v1, input logic [31:0] d1);
    valid0 = v0;
    rdata0 = d0;
    valid1 = v1;
    rdata1 = d1;
  endtask

  task automatic reset_dut;
    drive(1'b0, '0, 1'b0, '0);
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    drive(1'b0, '0, 1'b0, '0);
    rst = 1'b1;
    step;
    n_tests++;
    if ({valid_o, src_o, rdata_o, rtag_o, opc_o, aux_o, stall0, stall1, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%0b src=%0b rdata=%h ovf=%0b stall=%0b%0b, want all 0",
               valid_o, src_o, rdata_o, overflow, stall0, stall1);
    end
    rst = 1'b0;
    step;
    n_tests++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_valid: got %0b want 0", valid_o);
    end
  endtask

  task automatic test_single;
    reset_dut;
    repeat (4) step;
    drive(1'b1, 32'hA5A5_0001, 1'b0, '0);
    step;
    drive(1'b0, '0, 1'b0, '0);
    n_tests++;
    if (valid_o !== 1'b1 || rdata_o !== 32'hA5A5_0001 || src_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_out: got v=%0b d=%h s=%0b want v=1 d=a5a50001 s=0",
               valid_o, rdata_o, src_o);
    end
    n_tests++;
    if (rtag_o !== 4'h3 || opc_o !== 1'b0 || aux_o !== 6'h05) begin
      n_fail++;
      $display("FAIL single_fields: got tag=%h opc=%0b aux=%h want tag=3 opc=0 aux=05",
               rtag_o, opc_o, aux_o);
    end
    n_tests++;
    if (stall0 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_stall0: got %0b want 0", stall0);
    end
    step;
    n_tests++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse: got valid=%0b want 0", valid_o);
    end
  endtask

  // Collision from RR=0, then a second collision to expose the updated pointer.
  task automatic test_collision;
    logic [31:0] exp_d [4];
    logic        exp_s [4];
`ifdef FAN_IN_RESP_FIXED_PRIO_EN
    exp_d = '{32'h10, 32'h20, 32'h11, 32'h21};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_d = '{32'h10, 32'h20, 32'h21, 32'h11};
    exp_s = '{1'b0, 1'b1, 1'b1, 1'b0};
`endif
    reset_dut;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) drive(1'b1, 32'h10, 1'b1, 32'h20);
      else if (k == 2) drive(1'b1, 32'h11, 1'b1, 32'h21);
      else drive(1'b0, '0, 1'b0, '0);
      step;
      n_tests++;
      if (valid_o !== 1'b1 || rdata_o !== exp_d[k] || src_o !== exp_s[k]) begin
        n_fail++;
        $display("FAIL collision_%0d: got v=%0b d=%h s=%0b want v=1 d=%h s=%0b",
                 k, valid_o, rdata_o, src_o, exp_d[k], exp_s[k]);
      end
    end
    drive(1'b0, '0, 1'b0, '0);
    step;
    n_tests++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_idle: got valid=%0b want 0", valid_o);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d [4];
    logic        exp_s [4];
`ifdef FAN_IN_RESP_FIXED_PRIO_EN
    exp_d = '{32'h30, 32'h31, 32'h40, 32'h41};
    exp_s = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
    exp_d = '{32'h30, 32'h40, 32'h31, 32'h41};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    reset_dut;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) drive(1'b1, 32'h30, 1'b1, 32'h40);
      else if (k == 1) drive(1'b1, 32'h31, 1'b1, 32'h41);
      else drive(1'b0, '0, 1'b0, '0);
      step;
      n_tests++;
      if (valid_o !== 1'b1 || rdata_o !== exp_d[k] || src_o !== exp_s[k]) begin
        n_fail++;
        $display("FAIL b2b_%0d: got v=%0b d=%h s=%0b want v=1 d=%h s=%0b",
                 k, valid_o, rdata_o, src_o, exp_d[k], exp_s[k]);
      end
    end
  endtask

`ifndef FAN_IN_RESP_FIXED_PRIO_EN
  // 8 cycles of dual valid: winners alternate 0,1,0,1... for 16 cycles.
  task automatic test_sustained;
    logic [31:0] exp_d;
    logic        exp_s, exp_st0, exp_st1;
    reset_dut;
    for (int k = 0; k < 16; k++) begin
      if (k < 8) drive(1'b1, 32'hA00 + k, 1'b1, 32'hB00 + k);
      else drive(1'b0, '0, 1'b0, '0);
      step;
      exp_s = k[0];
      exp_d = (k[0] ? 32'hB00 : 32'hA00) + 32'(k / 2);
      n_tests++;
      if (valid_o !== 1'b1 || rdata_o !== exp_d || src_o !== exp_s) begin
        n_fail++;
        $display("FAIL sustained_out_%0d: got v=%0b d=%h s=%0b want v=1 d=%h s=%0b",
                 k, valid_o, rdata_o, src_o, exp_d, exp_s);
      end
      if (k < 8) begin
        exp_st1 = (k + 1 >= 5);
        exp_st0 = (k + 1 >= 6);
        n_tests++;
        if (stall0 !== exp_st0 || stall1 !== exp_st1) begin
          n_fail++;
          $display("FAIL sustained_stall_%0d: got s0=%0b s1=%0b want s0=%0b s1=%0b",
                   k, stall0, stall1, exp_st0, exp_st1);
        end
      end
    end
    step;
    n_tests++;
    if (valid_o !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL sustained_end: got valid=%0b ovf=%0b want 0 0", valid_o, overflow);
    end
  endtask

  // 10 cycles of dual valid: source-1 entry 8 and source-0 entry 9 are dropped.
  task automatic test_overflow;
    logic [31:0] got0 [$];
    logic [31:0] got1 [$];
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    for (int i = 0; i < 9; i++) exp0.push_back(32'hA00 + i);
    for (int i = 0; i < 8; i++) exp1.push_back(32'hB00 + i);
    exp1.push_back(32'hB09);
    reset_dut;
    for (int k = 0; k < 24; k++) begin
      if (k < 10) drive(1'b1, 32'hA00 + k, 1'b1, 32'hB00 + k);
      else drive(1'b0, '0, 1'b0, '0);
      step;
      if (valid_o === 1'b1) begin
        if (src_o) got1.push_back(rdata_o);
        else got0.push_back(rdata_o);
      end
      if (k == 7 || k == 8 || k == 23) begin
        n_tests++;
        if (overflow !== (k != 7)) begin
          n_fail++;
          $display("FAIL overflow_flag_%0d: got %0b want %0b", k, overflow, (k != 7));
        end
      end
    end
    n_tests++;
    if (got0.size() != exp0.size() || got1.size() != exp1.size()) begin
      n_fail++;
      $display("FAIL overflow_counts: got src0=%0d src1=%0d want src0=%0d src1=%0d",
               got0.size(), got1.size(), exp0.size(), exp1.size());
    end else begin
      for (int i = 0; i < exp0.size(); i++) begin
        n_tests++;
        if (got0[i] !== exp0[i]) begin
          n_fail++;
          $display("FAIL overflow_src0_%0d: got %h want %h", i, got0[i], exp0[i]);
        end
      end
      for (int i = 0; i < exp1.size(); i++) begin
        n_tests++;
        if (got1[i] !== exp1[i]) begin
          n_fail++;
          $display("FAIL overflow_src1_%0d: got %h want %h", i, got1[i], exp1[i]);
        end
      end
    end
  endtask
`endif

  task automatic test_reset_mid;
    reset_dut;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hC00 + k, 1'b1, 32'hD00 + k);
      step;
    end
    drive(1'b0, '0, 1'b0, '0);
    n_tests++;
    if (valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got valid=%0b want 1", valid_o);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({valid_o, src_o, rdata_o, stall0, stall1, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got valid=%0b src=%0b rdata=%h want all 0",
               valid_o, src_o, rdata_o);
    end
    step;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step;
      n_tests++;
      if (valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_stale_%0d: got valid=%0b d=%h want valid=0", k, valid_o, rdata_o);
      end
    end
    drive(1'b1, 32'hE0, 1'b0, '0);
    step;
    drive(1'b0, '0, 1'b0, '0);
    n_tests++;
    if (valid_o !== 1'b1 || rdata_o !== 32'hE0 || src_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_new: got v=%0b d=%h s=%0b want v=1 d=000000e0 s=0",
               valid_o, rdata_o, src_o);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_collision;
    test_back_to_back;
`ifndef FAN_IN_RESP_FIXED_PRIO_EN
    test_sustained;
    test_overflow;
`endif
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fan_in_resp_arbiter_bridge.md
Name: fan_in_resp_arbiter_bridge

Overview:
- Two-input response merger for the XBAR bridge; removes the rule that both response sources must never be valid in the same cycle.
- Each input has a small flow-through FIFO.
- A round-robin arbiter drains one response per cycle into a registered downstream port.
- Sits between two bridge response sources and the single downstream response channel.
- Raises per-input stall flags so the request side throttles before a FIFO overflows.

Parameters:
- DATA_WIDTH, 32, response data width
- AUX_WIDTH, 6, auxiliary/ID field width
- BYTE_NUM, DATA_WIDTH/8, bytes per word
- TAG_WIDTH, BYTE_NUM, response tag width
- FIFO_DEPTH, 4, entries per input FIFO; power of two, >=2
- STALL_TH, FIFO_DEPTH-1, occupancy at or above which stallN_o asserts

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- data_r_rdata0_i/1_i  in  DATA_WIDTH  response data, source 0/1
- data_r_rtag0_i/1_i  in  TAG_WIDTH  response tag, source 0/1
- data_r_opc0_i/1_i  in  1  opcode, source 0/1
- data_r_aux0_i/1_i  in  AUX_WIDTH  aux, source 0/1
- data_r_valid0_i/1_i  in  1  response valid, source 0/1; no backpressure
- data_r_rdata_o  out  DATA_WIDTH  merged data
- data_r_rtag_o  out  TAG_WIDTH  merged tag
- data_r_opc_o  out  1  merged opcode
- data_r_aux_o  out  AUX_WIDTH  merged aux
- data_r_valid_o  out  1  merged valid, one-cycle pulse per response
- data_r_src_o  out  1  source index of the current output
- stall0_o/stall1_o  out  1  FIFO0/1 occupancy >= STALL_TH
- overflow_o  out  1  sticky: a push hit a full FIFO

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0; FIFO pointers/counts 0; RR pointer = 0 (port 0 preferred first); overflow_o cleared.
- Push: validN_i=1 writes {rdata,rtag,opc,aux} into FIFO N the same cycle.
- Flow-through: an empty FIFO presents incoming data to the arbiter combinationally.
- Pop/arbitration, each cycle:
  - Candidates are the non-empty or flow-through FIFOs.
  - One candidate: it wins.
  - Two candidates: port RR pointer wins; RR pointer then moves to the loser.
  - At most one pop per cycle.
- Output register: winner payload, valid=1 and src registered; appears next cycle.
  - Latency: 1 cycle uncontended.
  - Loser waits at least 1 more cycle.
- No winner: valid_o=0 next cycle. Payload outputs hold their last value (don't care while valid=0).
- Occupancy, per FIFO: count' = count + push - pop.
  - Push and pop in the same cycle on a full FIFO is legal; count stays FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow: push to a full FIFO with no same-cycle pop on that FIFO.
  - The entry is dropped and stored contents are unchanged.
  - overflow_o sets and stays set until reset.
- Stall: stallN_o = (countN >= STALL_TH), combinational from registered count.
- Sustained dual valid: throughput is 1 response/cycle total, so occupancy grows by 1 every 2 cycles. The request side must honour stall.
- Ordering: per-source order preserved. No cross-source ordering guarantee.
- Reset mid-operation: all buffered responses discarded. The output valid drops asynchronously.

Optional Feature:
- Macro: FAN_IN_RESP_FIXED_PRIO_EN.
- Defined: fixed priority, FIFO0 always wins over FIFO1. RR pointer logic removed. FIFO1 can starve while FIFO0 is non-empty.
- Undefined (default): round-robin as above.

Decomposition:
- Package fan_in_resp_bridge_pkg holds:
  - parameterised-width response struct type {rdata, rtag, opc, aux}, or the equivalent packed-width localparams
  - PTR_W = $clog2(FIFO_DEPTH)
- Sub-module resp_fifo_flowthrough (instantiated twice): flow-through FIFO with push, pop, empty, full, count, data_o.
- Arbiter and output register are inline in the top.

Test Plan:
- Single source: valid0 pulse with rdata0=0xA5A5_0001 at cycle 5 -> valid_o=1, rdata_o=0xA5A5_0001, src_o=0 at cycle 6; stall0_o stays 0.
- Collision: valid0 and valid1 both high at cycle 10, data 0x10 and 0x20, RR=0.
  - Cycle 11: 0x10, src 0.
  - Cycle 12: 0x20, src 1.
  - RR pointer then 1.
- Sustained dual: both valid for 8 cycles with FIFO_DEPTH=4, STALL_TH=3.
  - stall asserts when count reaches 3 (cycle 6 of the burst).
  - 16 responses emerge over 16 consecutive cycles, per-source order intact.
  - overflow_o stays 0.
- Overflow: hold valid1 for 10 cycles while valid0 is held too; ignore stall.
  - overflow_o sets on the first dropped push and stays set.
  - Delivered source-1 data is in order with no corruption.
- Reset mid-burst: assert rst with 3 entries buffered.
  - Outputs go 0 immediately.
  - After release, no stale response appears.
  - A new valid0 is delivered after 1 cycle.
- FAN_IN_RESP_FIXED_PRIO_EN build: repeat the collision test -> source 0 is always first, including back-to-back collisions.
